// File: rtl/pwm_deadtime.sv
// Complementary high/low gate driver with programmable dead time, kill input and sticky fault.
// Optional macro PWM_DT_SYNC_EN adds a 2-flop synchronizer on pwm_i.
module pwm_deadtime #(
  parameter int DT_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        re_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  input  logic        pwm_i,
  input  logic        kill_i,
  output logic        hs_o,
  output logic        ls_o,
  output logic        oe_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOW   = 3'd1,
    DT_LH = 3'd2,
    HIGH  = 3'd3,
    DT_HL = 3'd4
  } state_e;

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_DT_RISE = 8'h04;
  localparam logic [7:0] ADDR_DT_FALL = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h0C;

  logic            pwm_s;
  logic [2:0]      ctrl_q;
  logic [DT_W-1:0] dt_rise_q, dt_fall_q;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            fault_q, fault_d;
  state_e          state_q, state_d;
  logic            hs_q, ls_q, oe_q;
  logic            wr_en, run;
  logic            unused_ok;

  assign unused_ok = ^{be_i, wdata_i[31:DT_W]};
  assign wr_en     = we_i & ~re_i;

`ifdef PWM_DT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b00;
    else         sync_q <= {sync_q[0], pwm_i};
  end

  assign pwm_s = sync_q[1];
`else
  assign pwm_s = pwm_i;
`endif

  // Kill bypasses the synchronizer so shutdown is never delayed by it.
  assign run     = ctrl_q[0] & ~fault_q & ~kill_i;
  assign fault_d = kill_i |
                   (fault_q & ~(wr_en && addr_i == ADDR_STATUS && wdata_i[0]));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!run) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, LOW: begin
          if (!pwm_s) begin
            state_d = LOW;
          end else if (dt_rise_q == '0) begin
            state_d = HIGH;
          end else begin
            state_d = DT_LH;
            cnt_d   = dt_rise_q;
          end
        end
        DT_LH: begin
          if (!pwm_s) begin
            state_d = LOW;
          end else if (cnt_q <= DT_W'(1)) begin
            state_d = HIGH;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        HIGH: begin
          if (!pwm_s) begin
            if (dt_fall_q == '0) begin
              state_d = LOW;
            end else begin
              state_d = DT_HL;
              cnt_d   = dt_fall_q;
            end
          end
        end
        DT_HL: begin
          if (pwm_s) begin
            state_d = HIGH;
          end else if (cnt_q <= DT_W'(1)) begin
            state_d = LOW;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registers, FSM state and outputs; outputs follow the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q    <= '0;
      dt_rise_q <= '0;
      dt_fall_q <= '0;
      fault_q   <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      hs_q      <= 1'b0;
      ls_q      <= 1'b0;
      oe_q      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (addr_i)
          ADDR_CTRL:    ctrl_q    <= wdata_i[2:0];
          ADDR_DT_RISE: dt_rise_q <= wdata_i[DT_W-1:0];
          ADDR_DT_FALL: dt_fall_q <= wdata_i[DT_W-1:0];
          default:      ;
        endcase
      end
      fault_q <= fault_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hs_q    <= (state_d == HIGH) ^ ctrl_q[1];
      ls_q    <= (state_d == LOW)  ^ ctrl_q[2];
      oe_q    <= (state_d != IDLE);
    end
  end

  assign hs_o = hs_q;
  assign ls_o = ls_q;
  assign oe_o = oe_q;

  always_comb begin
    rdata_o = '0;
    if (re_i) begin
      case (addr_i)
        ADDR_CTRL:    rdata_o[2:0]      = ctrl_q;
        ADDR_DT_RISE: rdata_o[DT_W-1:0] = dt_rise_q;
        ADDR_DT_FALL: rdata_o[DT_W-1:0] = dt_fall_q;
        ADDR_STATUS:  rdata_o[3:0]      = {state_q, fault_q};
        default:      rdata_o           = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Directed bench for pwm_deadtime (default build, no input synchronizer).
// Expected output triples {hs,ls,oe} go through a scoreboard queue.
module tb_pwm_deadtime;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re, we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        pwm, kill;
  logic        hs_o, ls_o, oe_o;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  typedef struct packed {
    logic hs;
    logic ls;
    logic oe;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pwm_deadtime #(.DT_W(8)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .re_i   (re),
    .we_i   (we),
    .addr_i (addr),
    .wdata_i(wdata),
    .be_i   (be),
    .rdata_o(rdata),
    .pwm_i  (pwm),
    .kill_i (kill),
    .hs_o   (hs_o),
    .ls_o   (ls_o),
    .oe_o   (oe_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: queue the expectation, advance, then compare what the DUT drove.
  task automatic step(input string tag, input logic [2:0] e);
    exp_t x;
    sb.push_back(exp_t'(e));
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk(tag, {29'd0, hs_o, ls_o, oe_o}, {29'd0, x.hs, x.ls, x.oe});
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input string tag,
                    input logic [2:0] e);
    we = 1'b1; addr = a; wdata = d;
    step(tag, e);
    we = 1'b0; addr = 8'h00; wdata = '0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    re = 1'b1; addr = a;
    #1;
    chk(tag, rdata, exp);
    re = 1'b0; addr = 8'h00;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; re = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = 4'hF;
    pwm = 1'b0; kill = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", {29'd0, hs_o, ls_o, oe_o}, 32'd0);
    rd(8'h00, 32'h0, "reset_ctrl");
    rd(8'h0C, 32'h0, "reset_status");
    rst_n = 1'b1;

    // Enable with pwm low: LOW one cycle after CTRL lands.
    wr(8'h00, 32'h1, "en_write", 3'b000);
    step("en_low", 3'b011);
    wr(8'h04, 32'd4, "dtr_write", 3'b011);
    wr(8'h08, 32'd2, "dtf_write", 3'b011);
    rd(8'h08, 32'd2, "dtf_read");
    rd(8'h10, 32'h0, "unmapped_read");
    wr(8'h10, 32'hFFFF_FFFF, "unmapped_write", 3'b011);
    rd(8'h00, 32'h1, "ctrl_after_unmapped");

    // 50-cycle square wave with DT_RISE=4, DT_FALL=2.
    for (int p = 0; p < 2; p++) begin
      pwm = 1'b1;
      for (int k = 0; k < 25; k++) begin
        step("sq_high", {logic'(k >= 4), 1'b0, 1'b1});
        chk("no_overlap", {31'd0, hs_o & ls_o}, 32'd0);
      end
      pwm = 1'b0;
      for (int k = 0; k < 25; k++) begin
        step("sq_low", {1'b0, logic'(k >= 2), 1'b1});
        chk("no_overlap", {31'd0, hs_o & ls_o}, 32'd0);
      end
    end

    // Glitch shorter than DT_RISE=6 returns to LOW.
    wr(8'h04, 32'd6, "dtr6_write", 3'b011);
    pwm = 1'b1;
    step("glitch_dt", 3'b001);
    rd(8'h0C, 32'h4, "glitch_status_dtlh");
    step("glitch_dt", 3'b001);
    step("glitch_dt", 3'b001);
    pwm = 1'b0;
    step("glitch_back", 3'b011);
    rd(8'h0C, 32'h2, "glitch_status_low");
    repeat (6) step("glitch_hold", 3'b011);

    // Zero dead time: hs rises on the same edge ls falls.
    wr(8'h04, 32'd0, "dtr0_write", 3'b011);
    pwm = 1'b1;
    step("zero_dt", 3'b101);
    rd(8'h0C, 32'h6, "status_high");

    // Kill in HIGH, enable ignored while faulted, W1C restarts.
    kill = 1'b1;
    step("kill", 3'b000);
    kill = 1'b0;
    rd(8'h0C, 32'h1, "fault_status");
    wr(8'h00, 32'h1, "en_ignored", 3'b000);
    step("fault_hold", 3'b000);
    step("fault_hold", 3'b000);
    wr(8'h0C, 32'h1, "w1c", 3'b000);
    step("restart", 3'b101);

    // Kill and W1C together: fault stays.
    kill = 1'b1;
    wr(8'h0C, 32'h1, "kill_w1c", 3'b000);
    kill = 1'b0;
    rd(8'h0C, 32'h1, "fault_stays");
    wr(8'h0C, 32'h1, "w1c2", 3'b000);
    step("restart2", 3'b101);

    // Polarity inversion on both sides.
    wr(8'h00, 32'h7, "pol_write", 3'b101);
    step("pol_high", 3'b011);
    pwm = 1'b0;
    step("pol_dt", 3'b111);
    step("pol_dt", 3'b111);
    step("pol_low", 3'b101);
    wr(8'h00, 32'h6, "dis_write", 3'b101);
    step("pol_idle", 3'b110);
    rd(8'h0C, 32'h0, "idle_status");

    // Re-enable, then asynchronous reset mid-operation.
    wr(8'h00, 32'h1, "reen_write", 3'b110);
    step("reen_low", 3'b011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", {29'd0, hs_o, ls_o, oe_o}, 32'd0);
    rd(8'h00, 32'h0, "async_reset_ctrl");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
